// File: rtl/fifo_pkt_pkg.sv
// Shared types and trailer-word helpers for the FIFO packet writer.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        TRAILER = 2'd2,
        DROP    = 2'd3
    } state_t;

    // Helpers are width-generic: they work on a wide vector and the caller
    // narrows the result to its own DATA_WIDTH.
    localparam int unsigned TRL_MAX_W = 64;

    // Trailer layout: overflow flag in the MSB, body length below it.
    function automatic int unsigned trl_ovf_bit(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned trl_len_msb(input int unsigned dw);
        return dw - 2;
    endfunction

    function automatic logic [TRL_MAX_W-1:0] trl_word(
        input logic                 ovf,
        input logic [TRL_MAX_W-1:0] len,
        input int unsigned          dw
    );
        logic [TRL_MAX_W-1:0] len_mask;
        len_mask = (TRL_MAX_W'(1) << (trl_len_msb(dw) + 1)) - TRL_MAX_W'(1);
        return (len & len_mask) | (TRL_MAX_W'(ovf) << trl_ovf_bit(dw));
    endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Write-side packet producer for the dual-clock FIFO (wr_clk domain).
// Forwards body words, appends a {ovf, len} trailer per packet, truncates
// packets longer than MAX_LEN and discards their remainder.
// Optional build macro FIFO_PKT_WRITER_AFULL_THROTTLE_EN: do not start a new
// packet while fifo_afull is high.
module fifo_pkt_writer
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    input  logic                  fifo_afull,
    output logic [STAT_WIDTH-1:0] pkt_cnt,
    output logic [STAT_WIDTH-1:0] trunc_cnt,
    output logic                  busy
);

    localparam int unsigned LEN_W = DATA_WIDTH - 1;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  ovf_q, ovf_d;
    logic [STAT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [STAT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;
    logic [DATA_WIDTH-1:0] trl_data;
    logic                  idle_block;

`ifdef FIFO_PKT_WRITER_AFULL_THROTTLE_EN
    assign idle_block = (state_q == IDLE) & fifo_afull;
`else
    logic afull_unused;
    assign afull_unused = fifo_afull;
    assign idle_block   = 1'b0;
`endif

    assign trl_data  = DATA_WIDTH'(trl_word(ovf_q, TRL_MAX_W'(len_q), DATA_WIDTH));
    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
    assign busy      = (state_q != IDLE);

    // Next-state, handshake and FIFO write-port decode.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        pkt_cnt_d    = pkt_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        in_ready     = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = in_data;
        unique case (state_q)
            IDLE, BODY: begin
                in_ready   = ~fifo_full & ~idle_block;
                fifo_wr_en = in_valid & ~idle_block;
                if (in_valid && in_ready) begin
                    len_d = len_q + LEN_W'(1);
                    if (in_last) begin
                        state_d = TRAILER;
                        ovf_d   = 1'b0;
                    end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
                        state_d = TRAILER;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            TRAILER: begin
                fifo_wr_en   = 1'b1;
                fifo_wr_data = trl_data;
                if (!fifo_full) begin
                    pkt_cnt_d   = pkt_cnt_q + STAT_WIDTH'(1);
                    trunc_cnt_d = trunc_cnt_q + STAT_WIDTH'(ovf_q);
                    len_d       = '0;
                    state_d     = ovf_q ? DROP : IDLE;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and statistics registers, asynchronously cleared.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer (MAX_LEN=4, 4-bit counters so wrap is reachable).
module tb_fifo_pkt_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned ML = 4;
    localparam int unsigned SW = 4;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full = 1'b0;
    logic          fifo_afull = 1'b0;
    logic [SW-1:0] pkt_cnt;
    logic [SW-1:0] trunc_cnt;
    logic          busy;

    fifo_pkt_writer #(.DATA_WIDTH(DW), .MAX_LEN(ML), .STAT_WIDTH(SW)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_afull(fifo_afull),
        .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int unsigned n;          // packet length in words
        logic [7:0]  base;       // word i carries base*(i+1)
        int unsigned stall_at;   // word index (n = trailer) where fifo_full is raised
        int unsigned stall_cyc;  // 0 = no stall
        logic        stall_rdy;  // expected in_ready while stalled
        logic [7:0]  exp_trl;    // expected trailer word
    } vec_t;

    vec_t          vecs[8];
    int            n_tests = 0;
    int            n_fail = 0;
    int            exp_pkt = 0;
    int            exp_trunc = 0;
    logic [DW-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted FIFO write must match the oldest expected word.
    always @(negedge wr_clk) begin
        if (wr_rst_n && fifo_wr_en && !fifo_full) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h required no write", fifo_wr_data);
            end else begin
                chk("fifo_wr_data", {24'd0, fifo_wr_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, output int unsigned cycles);
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int unsigned c = 1; c <= 40; c++) begin
            @(negedge wr_clk);
            rdy = in_ready;
            tick();
            if (rdy) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                cycles   = c;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got no in_ready required handshake");
        in_valid = 1'b0;
        in_last  = 1'b0;
        cycles   = 0;
    endtask

    task automatic drain_and_check(input int trunc_inc);
        for (int unsigned c = 0; c < 40 && sb.size() != 0; c++) tick();
        chk("drain_left", sb.size(), 0);
        exp_pkt++;
        exp_trunc += trunc_inc;
        chk("busy_after_pkt", {31'd0, busy}, 0);
        chk("pkt_cnt", {28'd0, pkt_cnt}, exp_pkt % (1 << SW));
        chk("trunc_cnt", {28'd0, trunc_cnt}, exp_trunc % (1 << SW));
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned   cyc;
        int unsigned   trl_at;
        logic [DW-1:0] d;
        logic          accepted;
        trl_at = (v.n > ML) ? ML - 1 : v.n - 1;
        for (int unsigned i = 0; i < v.n; i++) begin
            d = DW'(v.base * (i + 1));
            if (i < ML) sb.push_back(d);
            accepted = 1'b0;
            if (v.stall_cyc != 0 && v.stall_at == i) begin
                fifo_full = 1'b1;
                in_valid  = 1'b1;
                in_data   = d;
                in_last   = (i == v.n - 1);
                for (int unsigned k = 0; k < v.stall_cyc && !accepted; k++) begin
                    @(negedge wr_clk);
                    chk("stall_in_ready", {31'd0, in_ready}, {31'd0, v.stall_rdy});
                    tick();
                    if (v.stall_rdy) accepted = 1'b1;
                end
                fifo_full = 1'b0;
                if (accepted) begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end else begin
                    send_word(d, i == v.n - 1, cyc);
                end
            end else begin
                send_word(d, i == v.n - 1, cyc);
                chk("word_cycles", cyc, (i == ML && v.n > ML) ? 2 : 1);
            end
            if (i == trl_at) sb.push_back(v.exp_trl);
        end
        if (v.stall_cyc != 0 && v.stall_at == v.n) begin
            fifo_full = 1'b1;
            for (int unsigned k = 0; k < v.stall_cyc; k++) begin
                @(negedge wr_clk);
                chk("trl_hold_en", {31'd0, fifo_wr_en}, 1);
                chk("trl_hold_data", {24'd0, fifo_wr_data}, {24'd0, v.exp_trl});
                tick();
            end
            fifo_full = 1'b0;
        end
        drain_and_check((v.n > ML) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        vec_t        one;

        vecs[0] = '{3, 8'h11, 0, 0, 1'b0, 8'h03};
        vecs[1] = '{3, 8'h11, 1, 4, 1'b0, 8'h03};
        vecs[2] = '{6, 8'h11, 0, 0, 1'b0, 8'h84};
        vecs[3] = '{4, 8'h10, 0, 0, 1'b0, 8'h04};
        vecs[4] = '{1, 8'h5A, 0, 0, 1'b0, 8'h01};
        vecs[5] = '{6, 8'h21, 5, 3, 1'b1, 8'h84};
        vecs[6] = '{2, 8'h33, 0, 2, 1'b0, 8'h02};
        vecs[7] = '{2, 8'h07, 2, 3, 1'b0, 8'h02};

        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 0);
        chk("rst_pkt_cnt", {28'd0, pkt_cnt}, 0);
        chk("rst_trunc_cnt", {28'd0, trunc_cnt}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        wr_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a packet body.
        sb.push_back(8'h11);
        send_word(8'h11, 1'b0, cyc);
        sb.push_back(8'h22);
        send_word(8'h22, 1'b0, cyc);
        chk("mid_busy", {31'd0, busy}, 1);
        wr_rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, fifo_wr_en}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_pkt_cnt", {28'd0, pkt_cnt}, 0);
        exp_pkt   = 0;
        exp_trunc = 0;
        tick();
        wr_rst_n = 1'b1;
        tick();
        one = '{1, 8'hAA, 0, 0, 1'b0, 8'h01};
        run_vec(one);

        // Statistics counter wrap.
        one = '{1, 8'h3C, 0, 0, 1'b0, 8'h01};
        for (int i = 0; i < 17; i++) run_vec(one);

`ifdef FIFO_PKT_WRITER_AFULL_THROTTLE_EN
        fifo_afull = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        in_last    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wr_clk);
            chk("afull_idle_ready", {31'd0, in_ready}, 0);
            chk("afull_idle_wr_en", {31'd0, fifo_wr_en}, 0);
            tick();
        end
        fifo_afull = 1'b0;
        sb.push_back(8'h55);
        send_word(8'h55, 1'b0, cyc);
        fifo_afull = 1'b1;
        sb.push_back(8'h66);
        send_word(8'h66, 1'b1, cyc);
        chk("afull_body_cycles", cyc, 1);
        sb.push_back(8'h02);
        drain_and_check(0);
        fifo_afull = 1'b0;
`else
        fifo_afull = 1'b1;
        one = '{2, 8'h19, 0, 0, 1'b0, 8'h02};
        run_vec(one);
        fifo_afull = 1'b0;
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
